// File: rtl/mul_share_ctrl.sv
// ---------------------------------------------------------------------------
// mul_share_ctrl
//   Lets two ALU issue ports share one combinational WIDTH x WIDTH unsigned
//   array multiplier. A round-robin arbiter picks a requester and registers
//   its operands onto the multiplier inputs. The block then waits MC_CYCLES
//   for the ripple adder chain to settle. The product is captured into a
//   response register and held until the consumer pops it.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req0_valid/ready/md/mr   requester 0 operand handshake
//   req1_valid/ready/md/mr   requester 1 operand handshake
//   mul_md, mul_mr           registered operands driven into the multiplier
//   mul_product              combinational product returned by the multiplier
//   resp_valid/ready         result handshake toward the consumer
//   resp_id                  requester that owns the presented result
//   resp_product             captured 2*WIDTH product
//   busy                     high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module mul_share_ctrl #(
    parameter int WIDTH     = 16,
    parameter int MC_CYCLES = 3     // settle cycles, 1..15
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_md,
    input  logic [WIDTH-1:0]   req0_mr,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_md,
    input  logic [WIDTH-1:0]   req1_mr,

    output logic [WIDTH-1:0]   mul_md,
    output logic [WIDTH-1:0]   mul_mr,
    input  logic [2*WIDTH-1:0] mul_product,

    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_id,
    output logic [2*WIDTH-1:0] resp_product,

    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // WAIT runs cnt down from MC_CYCLES-1 to 0, giving MC_CYCLES settle cycles
    // between the operand register update and the product capture.
    localparam logic [3:0] CNT_INIT = 4'(MC_CYCLES - 1);

    state_t     state;
    logic       prio;       // requester favoured when both are valid
    logic       id_q;       // owner of the operation in flight
    logic [3:0] cnt;
    logic       grant0;
    logic       grant1;

    // Grant decode. It depends only on state, prio, rst and the request valids.
    // It has no path from resp_ready or mul_product, so the DONE->IDLE pop
    // cycle cannot also issue a new grant.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = ~prio;
                grant1 = prio;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            prio         <= 1'b0;
            id_q         <= 1'b0;
            cnt          <= '0;
            mul_md       <= '0;
            mul_mr       <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= 1'b0;
            resp_product <= '0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A grant is always a handshake: ready is only raised
                    // toward a requester whose valid is already high.
                    if (grant0 || grant1) begin
                        mul_md <= grant1 ? req1_md : req0_md;
                        mul_mr <= grant1 ? req1_mr : req0_mr;
                        id_q   <= grant1;
                        prio   <= ~grant1;
                        cnt    <= CNT_INIT;
                        state  <= WAIT;
                        busy   <= 1'b1;
                    end
                end

                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        resp_product <= mul_product;
                        resp_id      <= id_q;
                        resp_valid   <= 1'b1;
                        state        <= DONE;
                    end
                end

                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
